// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, reads imem, and queues {pc, insn} pairs for decode.
// One fetch per cycle when there is room; redirect flushes the queue and reloads the PC.
module fetch_queue #(
  parameter int              AWIDTH   = 32,
  parameter int              DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000,
  parameter int              DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [AWIDTH-1:0]          imem_addr_o,
  output logic                       imem_read_en_o,
  input  logic [DWIDTH-1:0]          imem_rdata_i,
  input  logic                       redirect_i,
  input  logic [AWIDTH-1:0]          redirect_pc_i,
  output logic                       insn_valid_o,
  input  logic                       insn_ready_i,
  output logic [AWIDTH-1:0]          pc_o,
  output logic [DWIDTH-1:0]          insn_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AWIDTH-1:0] r_pc;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [AWIDTH-1:0] r_mem_pc   [DEPTH];
  logic [DWIDTH-1:0] r_mem_insn [DEPTH];

  logic w_pop;
  logic w_push;

  assign insn_valid_o = (r_count != '0);
  assign w_pop        = insn_valid_o & insn_ready_i;
  // A full queue may still accept a fetch when the head leaves in the same cycle.
  assign w_push       = !rst & !redirect_i & ((r_count < FULL_CNT) | w_pop);

  assign imem_read_en_o = w_push;
  assign imem_addr_o    = r_pc;
  assign count_o        = r_count;
  assign pc_o           = insn_valid_o ? r_mem_pc[r_rd_ptr]   : '0;
  assign insn_o         = insn_valid_o ? r_mem_insn[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= BASEADDR;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_i) begin
      // A simultaneous pop still reaches decode; only its bookkeeping is dropped.
      r_pc     <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + AWIDTH'(4);
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_pc;
      r_mem_insn[r_wr_ptr] <= imem_rdata_i;
    end
  end

endmodule
